ssp_rx_ctrl: RTL and testbench

Receive-side controller for the SSP block. It deserialises TI-synchronous-serial frames from the external pins and sequences each completed byte into the RxFIFO through the FIFO's `rxdata`/`read_en` write port, honouring `flag_full`. It also keeps a sticky overrun status and a frame counter for the APB register file. It sits between the SSP pin interface and RxFIFO, and runs entirely in the `pclk` domain.

---
 rtl/ssp_rx_ctrl.sv | 131 +++++++++++++
 tb/tb_ssp_rx_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ssp_rx_ctrl.sv
// SSP receive controller: synchronises the serial pins, deserialises
// MSB-first frames and writes each completed byte into the RxFIFO.
module ssp_rx_ctrl #(
   parameter int DATA_W = 8
) (
   input  logic              pclk,
   input  logic              clr_b,
   input  logic              sspclkin,
   input  logic              sspfssin,
   input  logic              ssprxd,
   input  logic              flag_full,
   input  logic              ovr_clr,
   output logic [DATA_W-1:0] rxdata,
   output logic              read_en,
   output logic              rx_busy,
   output logic              rx_overrun,
   output logic [7:0]        frame_cnt
);

   localparam int CW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      SHIFT,
      PUSH
   } state_t;

   state_t              state_q;
   logic [2:0]          sclk_q;
   logic [1:0]          fss_q;
   logic [1:0]          rxd_q;
   logic [DATA_W-2:0]   sh_q;
   logic [CW-1:0]       bit_cnt_q;
   logic                rearm_q;
   logic [DATA_W-1:0]   rxdata_q;
   logic                read_en_q;
   logic                ovr_q;
   logic [7:0]          cnt_q;

   logic fall;
   logic fss;
   logic rxd;
   logic last;

   assign fall = sclk_q[2] & ~sclk_q[1];
   assign fss  = fss_q[1];
   assign rxd  = rxd_q[1];
   assign last = (bit_cnt_q == CW'(DATA_W - 1));

   // sclk_q[2] is the previous synchronised value used for edge detect
   always_ff @(posedge pclk) begin
      if (clr_b) begin
         sclk_q <= '0;
         fss_q  <= '0;
         rxd_q  <= '0;
      end else begin
         sclk_q <= {sclk_q[1:0], sspclkin};
         fss_q  <= {fss_q[0], sspfssin};
         rxd_q  <= {rxd_q[0], ssprxd};
      end
   end

   always_ff @(posedge pclk) begin
      if (clr_b) begin
         state_q   <= IDLE;
         sh_q      <= '0;
         bit_cnt_q <= '0;
         rearm_q   <= 1'b0;
         rxdata_q  <= '0;
         read_en_q <= 1'b0;
         ovr_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         // a drop later in this block overrides the clear
         if (ovr_clr) begin
            ovr_q <= 1'b0;
         end
         read_en_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (fall && fss) begin
                  state_q <= ARMED;
               end
            end
            ARMED: begin
               if (fall) begin
                  sh_q      <= {{(DATA_W-2){1'b0}}, rxd};
                  bit_cnt_q <= CW'(1);
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               if (fall) begin
                  if (last) begin
                     bit_cnt_q <= '0;
                     if (!flag_full) begin
                        rxdata_q  <= {sh_q, rxd};
                        read_en_q <= 1'b1;
                        rearm_q   <= fss;
                        state_q   <= PUSH;
                     end else begin
                        ovr_q   <= 1'b1;
                        state_q <= fss ? ARMED : IDLE;
                     end
                  end else if (fss) begin
                     bit_cnt_q <= '0;
                     state_q   <= ARMED;
                  end else begin
                     sh_q      <= {sh_q[DATA_W-3:0], rxd};
                     bit_cnt_q <= bit_cnt_q + CW'(1);
                  end
               end
            end
            PUSH: begin
               cnt_q   <= cnt_q + 8'd1;
               rearm_q <= 1'b0;
               state_q <= rearm_q ? ARMED : IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rxdata     = rxdata_q;
   assign read_en    = read_en_q;
   assign rx_overrun = ovr_q;
   assign frame_cnt  = cnt_q;
   assign rx_busy    = (state_q == ARMED) || (state_q == SHIFT);

endmodule

// File: tb/tb_ssp_rx_ctrl.sv
// Scoreboard bench for ssp_rx_ctrl: directed frames at sspclk = pclk/8,
// a monitor pops expected bytes on every read_en pulse.
module tb_ssp_rx_ctrl;

   logic       pclk = 1'b0;
   logic       clr_b = 1'b1;
   logic       sspclkin = 1'b0;
   logic       sspfssin = 1'b0;
   logic       ssprxd = 1'b0;
   logic       flag_full = 1'b0;
   logic       ovr_clr = 1'b0;
   logic [7:0] rxdata;
   logic       read_en;
   logic       rx_busy;
   logic       rx_overrun;
   logic [7:0] frame_cnt;

   int total = 0;
   int bad = 0;
   int pushes = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_cnt = 8'd0;
   logic       cnt_pend = 1'b0;
   logic       prev_re = 1'b0;

   ssp_rx_ctrl #(.DATA_W(8)) dut (
      .pclk       (pclk),
      .clr_b      (clr_b),
      .sspclkin   (sspclkin),
      .sspfssin   (sspfssin),
      .ssprxd     (ssprxd),
      .flag_full  (flag_full),
      .ovr_clr    (ovr_clr),
      .rxdata     (rxdata),
      .read_en    (read_en),
      .rx_busy    (rx_busy),
      .rx_overrun (rx_overrun),
      .frame_cnt  (frame_cnt)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // monitor: compares every pushed byte and the counter after it
   always @(negedge pclk) begin
      logic [7:0] e;
      if (cnt_pend) begin
         chk("frame_cnt_after_push", 32'(frame_cnt), 32'(exp_cnt));
         cnt_pend = 1'b0;
      end
      if (read_en) begin
         pushes++;
         chk("read_en_width", 32'(prev_re), 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_push", 32'(rxdata), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("rxdata", 32'(rxdata), 32'(e));
         end
         exp_cnt = exp_cnt + 8'd1;
         cnt_pend = 1'b1;
      end
      prev_re = read_en;
   end

   // one sspclk period (8 pclk); optional ovr_clr pulse in the fall cycle
   task automatic period(input logic f, input logic d, input logic clr);
      sspclkin = 1'b1;
      sspfssin = f;
      ssprxd   = d;
      repeat (4) @(negedge pclk);
      sspclkin = 1'b0;
      repeat (2) @(negedge pclk);
      if (clr) ovr_clr = 1'b1;
      @(negedge pclk);
      ovr_clr = 1'b0;
      @(negedge pclk);
   endtask

   task automatic frame(input logic [7:0] b, input logic pre,
                        input logic fl, input logic clr);
      if (pre) period(1'b1, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         period((i == 0) ? fl : 1'b0, b[i], (i == 0) ? clr : 1'b0);
      end
   endtask

   task automatic do_reset();
      clr_b = 1'b1;
      @(negedge pclk);
      clr_b = 1'b0;
      exp_cnt = 8'd0;
   endtask

   initial begin
      int p0;
      repeat (3) @(negedge pclk);
      clr_b = 1'b0;
      chk("rst_rxdata", 32'(rxdata), 32'd0);
      chk("rst_read_en", 32'(read_en), 32'd0);
      chk("rst_busy", 32'(rx_busy), 32'd0);
      chk("rst_ovr", 32'(rx_overrun), 32'd0);
      chk("rst_cnt", 32'(frame_cnt), 32'd0);
      repeat (4) @(negedge pclk);

      // single frame
      exp_q.push_back(8'hA5);
      frame(8'hA5, 1'b1, 1'b0, 1'b0);
      chk("single_rxdata", 32'(rxdata), 32'hA5);
      chk("single_cnt", 32'(frame_cnt), 32'd1);
      chk("single_ovr", 32'(rx_overrun), 32'd0);
      chk("single_idle", 32'(rx_busy), 32'd0);

      // back-to-back with fss overlapping the LSB
      exp_q.push_back(8'h3C);
      frame(8'h3C, 1'b1, 1'b1, 1'b0);
      chk("b2b_rearmed", 32'(rx_busy), 32'd1);
      exp_q.push_back(8'hC3);
      frame(8'hC3, 1'b0, 1'b0, 1'b0);
      chk("b2b_rxdata", 32'(rxdata), 32'hC3);
      chk("b2b_cnt", 32'(frame_cnt), 32'd3);

      // overrun
      flag_full = 1'b1;
      frame(8'hFF, 1'b1, 1'b0, 1'b0);
      chk("ovr_set", 32'(rx_overrun), 32'd1);
      chk("ovr_rxdata_hold", 32'(rxdata), 32'hC3);
      chk("ovr_cnt_hold", 32'(frame_cnt), 32'd3);
      frame(8'h12, 1'b1, 1'b0, 1'b1);
      chk("ovr_set_wins", 32'(rx_overrun), 32'd1);
      flag_full = 1'b0;
      ovr_clr = 1'b1;
      @(negedge pclk);
      ovr_clr = 1'b0;
      chk("ovr_cleared", 32'(rx_overrun), 32'd0);

      // mid-frame resync after 4 bits
      period(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) period(1'b0, i[0], 1'b0);
      exp_q.push_back(8'h81);
      frame(8'h81, 1'b1, 1'b0, 1'b0);
      chk("resync_rxdata", 32'(rxdata), 32'h81);
      chk("resync_cnt", 32'(frame_cnt), 32'd4);

      // reset mid-frame
      period(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) period(1'b0, 1'b1, 1'b0);
      chk("mid_busy", 32'(rx_busy), 32'd1);
      do_reset();
      chk("mrst_rxdata", 32'(rxdata), 32'd0);
      chk("mrst_read_en", 32'(read_en), 32'd0);
      chk("mrst_busy", 32'(rx_busy), 32'd0);
      chk("mrst_ovr", 32'(rx_overrun), 32'd0);
      chk("mrst_cnt", 32'(frame_cnt), 32'd0);
      repeat (3) @(negedge pclk);
      exp_q.push_back(8'h5A);
      frame(8'h5A, 1'b1, 1'b0, 1'b0);
      chk("post_rst_rxdata", 32'(rxdata), 32'h5A);
      chk("post_rst_cnt", 32'(frame_cnt), 32'd1);

      // counter wrap: 256 back-to-back frames
      do_reset();
      repeat (3) @(negedge pclk);
      p0 = pushes;
      for (int k = 0; k < 256; k++) begin
         exp_q.push_back(8'(k * 37 + 11));
         frame(8'(k * 37 + 11), (k == 0), (k != 255), 1'b0);
      end
      repeat (4) @(negedge pclk);
      chk("wrap_cnt", 32'(frame_cnt), 32'd0);
      chk("wrap_pushes", 32'(pushes - p0), 32'd256);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
